// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: two-stage immediate generator with valid/ready flow control.
// Ports: CLK/RST_n, flush, in_valid/in_ready + OP/PC4/ExtSel in, out_valid/out_ready + Out/out_err out.
module imm_ext_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       OP,
    input  logic [DATA_W-1:0] PC4,
    input  logic [2:0]        ExtSel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Out,
    output logic              out_err
);

    // Only the PC region above the 256 MB jump window is carried forward.
    localparam int PCU_W = DATA_W - 28;

    // Stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic [25:0]       op_q, op_d;
    logic [PCU_W-1:0]  pcu_q, pcu_d;
    logic [2:0]        sel_q, sel_d;

    // Stage 2 state
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              err_q, err_d;

    logic              s2_adv;
    logic              accept;
    logic              move;

    logic [15:0]       imm;
    logic [DATA_W-1:0] ext;
    logic              ext_err;

    logic              unused_pc;
    assign unused_pc = ^PC4[27:0];

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready && !flush;
    assign move     = s1_valid_q && s2_adv && !flush;

    // Extension datapath, fed from stage 1
    assign imm = op_q[15:0];

    always_comb begin
        ext     = '0;
        ext_err = 1'b0;
        unique case (sel_q)
            3'b000: ext = DATA_W'(op_q[10:6]);
            3'b001: ext = DATA_W'(imm);
            3'b010: ext = DATA_W'($signed(imm));
            3'b011: ext = DATA_W'($signed({imm, 16'h0000}));
            // Shift drops the top two bits of the sign-extended value.
            3'b100: ext = DATA_W'($signed(imm)) << 2;
            3'b101: ext = {pcu_q, op_q, 2'b00};
            default: begin
                ext     = '0;
                ext_err = 1'b1;
            end
        endcase
    end

    // Stage 1 next state: load on accept, drain on move, clear on flush.
    always_comb begin
        s1_valid_d = s1_valid_q;
        op_d       = op_q;
        pcu_d      = pcu_q;
        sel_d      = sel_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
            op_d       = OP[25:0];
            pcu_d      = PC4[DATA_W-1:28];
            sel_d      = ExtSel;
        end else if (move) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 next state: data only changes when a new entry arrives,
    // so Out holds while stalled and after draining.
    always_comb begin
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        err_d      = err_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (move) begin
            s2_valid_d = 1'b1;
            out_d      = ext;
            err_d      = ext_err;
        end else if (s2_adv) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            s1_valid_q <= 1'b0;
            op_q       <= '0;
            pcu_q      <= '0;
            sel_q      <= '0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            op_q       <= op_d;
            pcu_q      <= pcu_d;
            sel_q      <= sel_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            err_q      <= err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign Out       = out_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed checks of imm_ext_pipe at DATA_W 32 and 64.
// Stimulus and sampling happen on the falling clock edge.
module tb_imm_ext_pipe;

    logic        CLK;
    logic        RST_n;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] OP;
    logic [31:0] PC4;
    logic [2:0]  ExtSel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Out;
    logic        out_err;

    logic        flush64;
    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] OP64;
    logic [63:0] PC4_64;
    logic [2:0]  ExtSel64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] Out64;
    logic        out_err64;

    int n_cmp;
    int n_bad;

    imm_ext_pipe #(.DATA_W(32)) dut32 (
        .CLK(CLK), .RST_n(RST_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .OP(OP), .PC4(PC4), .ExtSel(ExtSel),
        .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .out_err(out_err)
    );

    imm_ext_pipe #(.DATA_W(64)) dut64 (
        .CLK(CLK), .RST_n(RST_n), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .OP(OP64), .PC4(PC4_64), .ExtSel(ExtSel64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .Out(Out64), .out_err(out_err64)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] op, input logic [2:0] sel);
        OP       = op;
        ExtSel   = sel;
        in_valid = 1'b1;
    endtask

    // Single isolated transfer through the 32-bit unit.
    task automatic send32(input string tag, input logic [31:0] op,
                          input logic [31:0] pc, input logic [2:0] sel,
                          input logic [63:0] exp, input logic experr);
        PC4 = pc;
        drive(op, sel);
        @(negedge CLK);
        in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(out_valid), 64'd0);
        @(negedge CLK);
        chk({tag, "_v"}, 64'(out_valid), 64'd1);
        chk(tag, 64'(Out), exp);
        chk({tag, "_err"}, 64'(out_err), 64'(experr));
    endtask

    task automatic send64(input string tag, input logic [31:0] op,
                          input logic [63:0] pc, input logic [2:0] sel,
                          input logic [63:0] exp);
        OP64       = op;
        PC4_64     = pc;
        ExtSel64   = sel;
        in_valid64 = 1'b1;
        @(negedge CLK);
        in_valid64 = 1'b0;
        @(negedge CLK);
        chk({tag, "_v"}, 64'(out_valid64), 64'd1);
        chk(tag, Out64, exp);
        chk({tag, "_err"}, 64'(out_err64), 64'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        RST_n       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        OP          = '0;
        PC4         = '0;
        ExtSel      = '0;
        out_ready   = 1'b1;
        flush64     = 1'b0;
        in_valid64  = 1'b0;
        OP64        = '0;
        PC4_64      = '0;
        ExtSel64    = '0;
        out_ready64 = 1'b1;

        // Reset values
        #2 RST_n = 1'b0;
        #1;
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(Out), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
        chk("rst_ir", 64'(in_ready), 64'd1);
        chk("rst_out64", Out64, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;

        // Mode sweep, 32-bit
        send32("shamt", 32'h0000_07C0, 32'h0, 3'b000, 64'h0000_001F, 1'b0);
        send32("zext", 32'h0000_8000, 32'h0, 3'b001, 64'h0000_8000, 1'b0);
        send32("sext", 32'h0000_8000, 32'h0, 3'b010, 64'hFFFF_8000, 1'b0);
        send32("lui", 32'h0000_1234, 32'h0, 3'b011, 64'h1234_0000, 1'b0);
        send32("br", 32'h0000_FFFF, 32'h0, 3'b100, 64'hFFFF_FFFC, 1'b0);
        send32("jmp", 32'h0800_0010, 32'h4000_0004, 3'b101,
               64'h4000_0040, 1'b0);
        send32("rsv6", 32'hFFFF_FFFF, 32'h0, 3'b110, 64'h0, 1'b1);
        send32("rsv7", 32'h0000_1234, 32'h0, 3'b111, 64'h0, 1'b1);

        // Mode checks, 64-bit
        send64("lui64", 32'h0000_8000, 64'h0, 3'b011,
               64'hFFFF_FFFF_8000_0000);
        send64("jmp64", 32'h0800_0010, 64'h1234_5678_9000_0004, 3'b101,
               64'h1234_5678_9000_0040);

        // Streaming: 8 back-to-back with out_ready high
        @(negedge CLK);
        for (int c = 0; c < 10; c++) begin
            if (c < 8)
                chk($sformatf("st_ir%0d", c), 64'(in_ready), 64'd1);
            if (c < 2) begin
                chk($sformatf("st_ov%0d", c), 64'(out_valid), 64'd0);
            end else begin
                chk($sformatf("st_ov%0d", c), 64'(out_valid), 64'd1);
                chk($sformatf("st_out%0d", c), 64'(Out),
                    64'h1000 + 64'(c - 2));
            end
            if (c < 8)
                drive(32'h0000_1000 + 32'(c), 3'b001);
            else
                in_valid = 1'b0;
            @(negedge CLK);
        end
        chk("st_end", 64'(out_valid), 64'd0);

        // Back-pressure: out_ready low for 5 cycles
        out_ready = 1'b0;
        chk("bp_ir0", 64'(in_ready), 64'd1);
        drive(32'h0000_A001, 3'b001);
        @(negedge CLK);
        chk("bp_ir1", 64'(in_ready), 64'd1);
        drive(32'h0000_A002, 3'b001);
        @(negedge CLK);
        drive(32'h0000_A003, 3'b001);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_stall_ir%0d", k), 64'(in_ready), 64'd0);
            chk($sformatf("bp_stall_ov%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp_stall_out%0d", k), 64'(Out), 64'hA001);
            @(negedge CLK);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ir", 64'(in_ready), 64'd1);
        chk("bp_rel_out", 64'(Out), 64'hA001);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("bp_b_ov", 64'(out_valid), 64'd1);
        chk("bp_b", 64'(Out), 64'hA002);
        @(negedge CLK);
        chk("bp_c_ov", 64'(out_valid), 64'd1);
        chk("bp_c", 64'(Out), 64'hA003);
        @(negedge CLK);
        chk("bp_end", 64'(out_valid), 64'd0);

        // Flush with both stages full and a new input presented
        out_ready = 1'b0;
        drive(32'h0000_0011, 3'b001);
        @(negedge CLK);
        drive(32'h0000_0022, 3'b001);
        @(negedge CLK);
        chk("fl_pre", 64'(Out), 64'h11);
        out_ready = 1'b1;
        flush     = 1'b1;
        drive(32'h0000_0033, 3'b001);
        #1;
        chk("fl_ir", 64'(in_ready), 64'd1);
        @(negedge CLK);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_ov", 64'(out_valid), 64'd0);
        chk("fl_keep", 64'(Out), 64'h11);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("fl_gone%0d", k), 64'(out_valid), 64'd0);
        end
        chk("fl_keep2", 64'(Out), 64'h11);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(32'h0000_00AA, 3'b001);
        @(negedge CLK);
        drive(32'h0000_00BB, 3'b001);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("ar_pre", 64'(Out), 64'hAA);
        #2 RST_n = 1'b0;
        #1;
        chk("ar_ov", 64'(out_valid), 64'd0);
        chk("ar_out", 64'(Out), 64'd0);
        chk("ar_err", 64'(out_err), 64'd0);
        chk("ar_ir", 64'(in_ready), 64'd1);
        @(negedge CLK);
        RST_n     = 1'b1;
        out_ready = 1'b1;
        drive(32'h0000_0055, 3'b001);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("ar_lat", 64'(out_valid), 64'd0);
        @(negedge CLK);
        chk("ar_first_ov", 64'(out_valid), 64'd1);
        chk("ar_first", 64'(Out), 64'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
